// File: rtl/mem_access_fsm.sv
// -----------------------------------------------------------------------------
// mem_access_fsm
//
// Access sequencer for the memory/pixel array. Accepts host read/write
// requests and drives the array's enable, direction, address and write data
// through WRITE -> STABLE -> (READ) phases of configurable length. With VERIFY
// set, every write is followed by a read-back and a mismatch raises
// verify_err. Back-to-back requests are accepted on the last cycle of a phase
// that would otherwise return to IDLE, so no IDLE bubble is inserted.
//
// State codes (kept from the original 2-bit controller):
//   IDLE=2'b10, WRITE=2'b11, STABLE=2'b00, READ=2'b01
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   sel, op           request strobe; op 1 = write, 0 = read
//   addr, wdata       request address / write data
//   ready             combinational: a request with sel=1 is taken this cycle
//   mem_en, mem_rw    array enable and direction (1 = write)
//   mem_addr          latched request address
//   mem_wdata         latched request write data
//   mem_rdata         array read data
//   valid             one-cycle pulse when rdata has been updated
//   rdata             last captured read data
//   verify_err        read-back mismatch, sticky until the next accepted request
//   state             current state code
// -----------------------------------------------------------------------------
module mem_access_fsm #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int WRITE_CYCLES  = 1,
    parameter int STABLE_CYCLES = 2,
    parameter int READ_CYCLES   = 1,
    parameter int VERIFY        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              valid,
    output logic [DATA_W-1:0] rdata,
    output logic              verify_err,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b10,
        ST_WRITE  = 2'b11,
        ST_STABLE = 2'b00,
        ST_READ   = 2'b01
    } state_t;

    // Counter reload values: each phase counts down from length-1 to 0.
    localparam logic [3:0] WR_LAST = 4'(WRITE_CYCLES - 1);
    localparam logic [3:0] ST_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] RD_LAST = 4'(READ_CYCLES - 1);

    // Read-back comparison helper.
    function automatic logic data_mismatch(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
        return (a != b);
    endfunction

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic                mem_en_r, mem_en_s;
    logic                mem_rw_r, mem_rw_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                valid_r, valid_s;
    logic                verify_err_r, verify_err_s;
    logic                vflag_r, vflag_s;
    logic                ready_s;
    logic                accept_s;
    logic                capture_s;

    // Ready: IDLE, last READ cycle, or last STABLE cycle when no read-back follows.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
            end
            ST_READ: begin
                ready_s = (cnt_r == 4'd0);
            end
            ST_STABLE: begin
                if (VERIFY == 0) begin
                    ready_s = (cnt_r == 4'd0);
                end else begin
                    ready_s = 1'b0;
                end
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Next-state, phase counter and next-cycle output values.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        mem_en_s     = mem_en_r;
        mem_rw_s     = mem_rw_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        rdata_s      = rdata_r;
        valid_s      = 1'b0;
        verify_err_s = verify_err_r;
        vflag_s      = vflag_r;
        capture_s    = 1'b0;
        accept_s     = sel & ready_s;

        case (state_r)
            ST_IDLE: begin
                mem_en_s = 1'b0;
                mem_rw_s = 1'b0;
            end
            ST_WRITE: begin
                if (cnt_r == 4'd0) begin
                    state_s  = ST_STABLE;
                    cnt_s    = ST_LAST;
                    mem_en_s = 1'b0;
                    mem_rw_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_STABLE: begin
                if (cnt_r == 4'd0) begin
                    if (VERIFY != 0) begin
                        // Read back the same address just written.
                        state_s  = ST_READ;
                        cnt_s    = RD_LAST;
                        mem_en_s = 1'b1;
                        mem_rw_s = 1'b0;
                        vflag_s  = 1'b1;
                    end else begin
                        state_s  = ST_IDLE;
                        cnt_s    = 4'd0;
                        mem_en_s = 1'b0;
                        mem_rw_s = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_READ: begin
                if (cnt_r == 4'd0) begin
                    capture_s = 1'b1;
                    rdata_s   = mem_rdata;
                    valid_s   = 1'b1;
                    state_s   = ST_IDLE;
                    cnt_s     = 4'd0;
                    mem_en_s  = 1'b0;
                    mem_rw_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                cnt_s    = 4'd0;
                mem_en_s = 1'b0;
                mem_rw_s = 1'b0;
                vflag_s  = 1'b0;
            end
        endcase

        // An accepted request overrides the phase exit chosen above; this is
        // what lets a new request follow without an IDLE cycle.
        if (accept_s) begin
            mem_addr_s   = addr;
            mem_wdata_s  = wdata;
            verify_err_s = 1'b0;
            vflag_s      = 1'b0;
            mem_en_s     = 1'b1;
            mem_rw_s     = op;
            if (op) begin
                state_s = ST_WRITE;
                cnt_s   = WR_LAST;
            end else begin
                state_s = ST_READ;
                cnt_s   = RD_LAST;
            end
        end else begin
            mem_addr_s = mem_addr_s;
        end

        // A read-back mismatch is reported even if the next request is taken
        // on the same edge, so it belongs to the write that just completed.
        // The comparison uses the write data latched before that edge.
        if (capture_s && vflag_r && data_mismatch(mem_rdata, mem_wdata_r)) begin
            verify_err_s = 1'b1;
        end else begin
            verify_err_s = verify_err_s;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            mem_en_r     <= 1'b0;
            mem_rw_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
            valid_r      <= 1'b0;
            verify_err_r <= 1'b0;
            vflag_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            mem_en_r     <= mem_en_s;
            mem_rw_r     <= mem_rw_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            rdata_r      <= rdata_s;
            valid_r      <= valid_s;
            verify_err_r <= verify_err_s;
            vflag_r      <= vflag_s;
        end
    end

    assign ready      = ready_s;
    assign mem_en     = mem_en_r;
    assign mem_rw     = mem_rw_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign valid      = valid_r;
    assign rdata      = rdata_r;
    assign verify_err = verify_err_r;
    assign state      = state_r;

endmodule

// File: tb/tb_mem_access_fsm.sv
// -----------------------------------------------------------------------------
// Bench for mem_access_fsm. dut0 uses the default parameters (read-back on),
// dut1 uses VERIFY=0, STABLE_CYCLES=3, READ_CYCLES=2. Each has its own
// behavioural memory. Expected read results are pushed to a per-DUT queue when
// the request is issued and popped when the DUT raises valid.
// -----------------------------------------------------------------------------
module tb_mem_access_fsm;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       sel0, op0, ready0, mem_en0, mem_rw0, valid0, verr0;
    logic [7:0] addr0, wdata0, mem_addr0, mem_wdata0, mem_rdata0, rdata0;
    logic [1:0] state0;
    logic       sel1, op1, ready1, mem_en1, mem_rw1, valid1, verr1;
    logic [7:0] addr1, wdata1, mem_addr1, mem_wdata1, mem_rdata1, rdata1;
    logic [1:0] state1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       force0;
    logic [7:0] force_val0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        logic       verr;
        int         cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    mem_access_fsm dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .op(op0), .addr(addr0),
        .wdata(wdata0), .ready(ready0), .mem_en(mem_en0), .mem_rw(mem_rw0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
        .valid(valid0), .rdata(rdata0), .verify_err(verr0), .state(state0)
    );

    mem_access_fsm #(
        .STABLE_CYCLES(3), .READ_CYCLES(2), .VERIFY(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel1), .op(op1), .addr(addr1),
        .wdata(wdata1), .ready(ready1), .mem_en(mem_en1), .mem_rw(mem_rw1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .valid(valid1), .rdata(rdata1), .verify_err(verr1), .state(state1)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 3) + 1);
    endfunction

    // Cycle counter used to time valid pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memories, preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= init_val(i);
                mem1[i] <= init_val(i);
            end
        end else begin
            if (mem_en0 && mem_rw0) mem0[mem_addr0] <= mem_wdata0;
            if (mem_en1 && mem_rw1) mem1[mem_addr1] <= mem_wdata1;
        end
    end

    assign mem_rdata0 = force0 ? force_val0 : mem0[mem_addr0];
    assign mem_rdata1 = mem1[mem_addr1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for dut0.
    always @(negedge clk) begin
        exp_t e;
        if (valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut0_spurious_valid", {31'd0, valid0}, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0_rdata", {24'd0, rdata0}, {24'd0, e.data});
                chk("dut0_verify_err", {31'd0, verr0}, {31'd0, e.verr});
                chk("dut0_valid_cycle", cyc, e.cyc);
            end
        end
    end

    // Scoreboard for dut1.
    always @(negedge clk) begin
        exp_t e;
        if (valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1_spurious_valid", {31'd0, valid1}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1_rdata", {24'd0, rdata1}, {24'd0, e.data});
                chk("dut1_verify_err", {31'd0, verr1}, {31'd0, e.verr});
                chk("dut1_valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue0(input logic o, input logic [7:0] a, input logic [7:0] d);
        sel0 = 1'b1; op0 = o; addr0 = a; wdata0 = d;
    endtask

    task automatic issue1(input logic o, input logic [7:0] a, input logic [7:0] d);
        sel1 = 1'b1; op1 = o; addr1 = a; wdata1 = d;
    endtask

    // Called in the accept cycle of a dut0 write; walks the five following cycles.
    task automatic check_write_seq0(input string tag);
        logic [1:0] st [5];
        logic       en [5];
        logic       rw [5];
        logic       rd [5];
        st = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b10};
        en = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        rw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) sel0 = 1'b0;
            chk($sformatf("%s_state%0d", tag, i), {30'd0, state0}, {30'd0, st[i]});
            chk($sformatf("%s_mem_en%0d", tag, i), {31'd0, mem_en0}, {31'd0, en[i]});
            chk($sformatf("%s_mem_rw%0d", tag, i), {31'd0, mem_rw0}, {31'd0, rw[i]});
            chk($sformatf("%s_ready%0d", tag, i), {31'd0, ready0}, {31'd0, rd[i]});
        end
    endtask

    initial begin
        logic [1:0] st1 [5];
        logic       en1 [5];
        logic       rd1 [5];
        logic [1:0] st2 [3];
        logic       en2 [3];
        logic       rd2 [3];
        st1 = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10};
        en1 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rd1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        st2 = '{2'b01, 2'b01, 2'b10};
        en2 = '{1'b1, 1'b1, 1'b0};
        rd2 = '{1'b0, 1'b1, 1'b1};

        // Reset with a write request already on sel.
        rst_n = 1'b0;
        sel0 = 1'b1; op0 = 1'b1; addr0 = 8'h3C; wdata0 = 8'hA5;
        sel1 = 1'b0; op1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        force0 = 1'b0; force_val0 = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", {30'd0, state0}, 32'd2);
            chk("rst_mem_en", {31'd0, mem_en0}, 32'd0);
            chk("rst_valid", {31'd0, valid0}, 32'd0);
        end
        chk("rst_rdata", {24'd0, rdata0}, 32'd0);
        chk("rst_verify_err", {31'd0, verr0}, 32'd0);
        chk("rst_state1", {30'd0, state1}, 32'd2);

        // Write with read-back, accepted on the first edge after release.
        rst_n = 1'b1;
        chk("t1_ready", {31'd0, ready0}, 32'd1);
        q0.push_back('{data: 8'hA5, verr: 1'b0, cyc: cyc + 5});
        check_write_seq0("t1");
        chk("t1_mem_addr", {24'd0, mem_addr0}, 32'h3C);
        chk("t1_mem_wdata", {24'd0, mem_wdata0}, 32'hA5);

        // Read-back mismatch.
        force0 = 1'b1; force_val0 = 8'h5A;
        issue0(1'b1, 8'h3C, 8'hA5);
        q0.push_back('{data: 8'h5A, verr: 1'b1, cyc: cyc + 5});
        check_write_seq0("t2");
        force0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t2_verr_sticky", {31'd0, verr0}, 32'd1);
        end
        issue0(1'b0, 8'h3C, 8'h00);
        q0.push_back('{data: 8'hA5, verr: 1'b0, cyc: cyc + 2});
        @(negedge clk);
        sel0 = 1'b0;
        chk("t2_verr_clear", {31'd0, verr0}, 32'd0);
        chk("t2_read_state", {30'd0, state0}, 32'd1);
        @(negedge clk);
        chk("t2_idle", {30'd0, state0}, 32'd2);

        // Back-to-back: read 0x10 then a write taken on the last READ cycle.
        issue0(1'b0, 8'h10, 8'h00);
        q0.push_back('{data: init_val(16), verr: 1'b0, cyc: cyc + 2});
        @(negedge clk);
        chk("t3_read_state", {30'd0, state0}, 32'd1);
        chk("t3_read_addr", {24'd0, mem_addr0}, 32'h10);
        chk("t3_ready_last_read", {31'd0, ready0}, 32'd1);
        issue0(1'b1, 8'h20, 8'h77);
        q0.push_back('{data: 8'h77, verr: 1'b0, cyc: cyc + 5});
        check_write_seq0("t3");
        chk("t3_mem_addr", {24'd0, mem_addr0}, 32'h20);

        // Reset during the first STABLE cycle.
        issue0(1'b1, 8'h40, 8'h11);
        @(negedge clk);
        sel0 = 1'b0;
        chk("t4_write", {30'd0, state0}, 32'd3);
        @(negedge clk);
        chk("t4_stable", {30'd0, state0}, 32'd0);
        chk("t4_stable_rw", {31'd0, mem_rw0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_async_state", {30'd0, state0}, 32'd2);
        chk("t4_async_mem_en", {31'd0, mem_en0}, 32'd0);
        chk("t4_async_mem_rw", {31'd0, mem_rw0}, 32'd0);
        chk("t4_async_mem_addr", {24'd0, mem_addr0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t4_no_valid", {31'd0, valid0}, 32'd0);
            chk("t4_idle", {30'd0, state0}, 32'd2);
        end

        // VERIFY=0, STABLE=3, READ=2.
        chk("t5_ready", {31'd0, ready1}, 32'd1);
        issue1(1'b1, 8'h05, 8'h99);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) sel1 = 1'b0;
            chk($sformatf("t5w_state%0d", i), {30'd0, state1}, {30'd0, st1[i]});
            chk($sformatf("t5w_mem_en%0d", i), {31'd0, mem_en1}, {31'd0, en1[i]});
            chk($sformatf("t5w_ready%0d", i), {31'd0, ready1}, {31'd0, rd1[i]});
        end
        issue1(1'b0, 8'h05, 8'h00);
        q1.push_back('{data: 8'h99, verr: 1'b0, cyc: cyc + 3});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) sel1 = 1'b0;
            chk($sformatf("t5r_state%0d", i), {30'd0, state1}, {30'd0, st2[i]});
            chk($sformatf("t5r_mem_en%0d", i), {31'd0, mem_en1}, {31'd0, en2[i]});
            chk($sformatf("t5r_ready%0d", i), {31'd0, ready1}, {31'd0, rd2[i]});
        end

        // Every queued result must have been produced within a bounded wait.
        for (int i = 0; i < 20; i++) begin
            if (q0.size() != 0 || q1.size() != 0) @(negedge clk);
        end
        chk("scoreboard_drain", q0.size() + q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_fsm.md
Name: mem_access_fsm

Overview:
- Parametrised successor to the 2-bit IDLE/WRITE/STABLE/READ access controller for the memory array.
- Accepts host read/write requests and sequences memory enable, read/write and address over configurable write, stabilise and read phase lengths.
- Optionally reads back every write and flags mismatches, and supports back-to-back requests without an IDLE bubble.
- Sits between the top-level control sequencer and the memory/pixel array macro.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- WRITE_CYCLES, 1, cycles in WRITE (legal range 1..15).
- STABLE_CYCLES, 2, cycles in STABLE (legal range 1..15).
- READ_CYCLES, 1, cycles in READ (legal range 1..15).
- VERIFY, 1, 1 = read-back after each write; 0 = STABLE returns to IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sel  in  1  request strobe (selFSM successor).
- op  in  1  request type: 1 = write, 0 = read.
- addr  in  ADDR_W  request address.
- wdata  in  DATA_W  write data.
- ready  out  1  request is accepted this cycle if sel=1.
- mem_en  out  1  memory enable.
- mem_rw  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data.
- valid  out  1  one-cycle pulse: rdata is updated.
- rdata  out  DATA_W  last captured read data.
- verify_err  out  1  read-back mismatch; sticky until next accepted request.
- state  out  2  state code: IDLE=10, WRITE=11, STABLE=00, READ=01.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE(10); counter=0.
  - mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, rdata=0, valid=0, verify_err=0.
  - sel is ignored while rst_n is low.
- Reset mid-operation: the access is aborted, mem_en drops immediately, no valid is produced, the latched request is discarded.
- Accept: a request is accepted on a rising edge with sel=1 and ready=1.
  - On accept, addr/wdata/op are latched and verify_err clears.
  - op=1 goes to WRITE; op=0 goes to READ.
- ready=1 in:
  - IDLE;
  - the last READ cycle;
  - the last STABLE cycle when VERIFY=0.
  - 0 elsewhere; ready is combinational from state and counter.
- Phase counter: loads phase length-1 on entry and decrements; the phase ends when the counter reaches 0.
- WRITE: mem_en=1, mem_rw=1 for WRITE_CYCLES cycles, then STABLE.
- STABLE: mem_en=0, mem_rw=1 held for STABLE_CYCLES cycles.
  - VERIFY=1: go to READ with verify flag set; same mem_addr.
  - VERIFY=0: go to IDLE, or go directly to the next request if one is accepted on the last cycle.
- READ: mem_en=1, mem_rw=0 for READ_CYCLES cycles.
  - mem_rdata is sampled at the end of the last cycle into rdata.
  - valid=1 for exactly the following cycle.
  - If the verify flag is set, verify_err is set in that same cycle when mem_rdata != latched wdata.
  - Exit: back-to-back write goes to WRITE, back-to-back read re-enters READ with the new address, otherwise IDLE.
- Latency (defaults): write accept to valid of read-back = 5 cycles (W1+S2+R1+1); read accept to valid = 2 cycles.
- Illegal 2-bit encodings cannot occur; the default branch returns to IDLE.
- Outputs other than ready are registered.

Test Plan:
- Reset: rst_n=0 then release, with sel=1 op=1 held during reset -> state=10, mem_en=0, valid=0 throughout reset; the request is accepted on the first edge after release.
- Write with read-back: write addr=0x3C, wdata=0xA5, memory model returns 0xA5 ->
  - state sequence 11, 00, 00, 01, 10;
  - mem_en high 1 cycle write, low 2, high 1 read;
  - valid pulses 5 cycles after accept with rdata=0xA5, verify_err=0.
- Verify mismatch: same write, memory model forces read value 0x5A -> valid with rdata=0x5A and verify_err=1; verify_err stays 1 until the next accept, then clears.
- Back-to-back: read 0x10 followed by a write held on sel, op=1 -> no IDLE cycle between 01 and 11; the second accept happens on the last READ cycle.
- Reset mid-operation: assert rst_n=0 during the first STABLE cycle -> mem_en=0 and state=10 immediately (async); no valid pulse after release.
- VERIFY=0 with STABLE_CYCLES=3 and READ_CYCLES=2 -> write sequence 11, 00, 00, 00, 10 with no READ; a read accept gives mem_en high 2 cycles and valid 3 cycles after accept.
